// File: rtl/rv32_w_writeback_arbiter.sv
// Register-file write port 3 arbiter: fixed-priority pipeline writeback merged
// with a FIFO-buffered long-latency result stream, outputs registered on posedge.
module rv32_w_writeback_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            pipe_valid_i,
  input  logic [4:0]                      pipe_address_i,
  input  logic [31:0]                     pipe_data_i,
  input  logic                            lu_valid_i,
  output logic                            lu_ready_o,
  input  logic [4:0]                      lu_address_i,
  input  logic [31:0]                     lu_data_i,
  output logic                            stall_o,
  output logic                            write_enable_3_o,
  output logic [4:0]                      write_address_3_o,
  output logic [31:0]                     write_data_3_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [36:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic [SW-1:0] starve_r;
  logic [SW-1:0] starve_next_s;
  logic          stall_r;
  logic          stall_next_s;
  logic          we_r;
  logic          we_next_s;
  logic [4:0]    addr_r;
  logic [4:0]    addr_next_s;
  logic [31:0]   data_r;
  logic [31:0]   data_next_s;
  logic          ready_s;
  logic          push_s;
  logic          pop_s;
  logic          pipe_take_s;
  logic          empty_s;

  assign ready_s     = rst_ni & (count_r != FULL_COUNT);
  assign empty_s     = (count_r == {CW{1'b0}});
  assign pipe_take_s = pipe_valid_i & (pipe_address_i != 5'd0);
  // x0 results are acknowledged but never stored
  assign push_s      = lu_valid_i & ready_s & (lu_address_i != 5'd0);
  assign pop_s       = ~pipe_take_s & ~empty_s;

  // Slot selection: pipeline first, then FIFO head, else idle with held address/data
  always_comb begin
    we_next_s   = 1'b0;
    addr_next_s = addr_r;
    data_next_s = data_r;
    if (pipe_take_s) begin
      we_next_s   = 1'b1;
      addr_next_s = pipe_address_i;
      data_next_s = pipe_data_i;
    end else if (!empty_s) begin
      we_next_s   = 1'b1;
      addr_next_s = mem_r[rd_ptr_r][36:32];
      data_next_s = mem_r[rd_ptr_r][31:0];
    end else begin
      we_next_s   = 1'b0;
    end
  end

  // Occupancy update from push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Starvation tracking: saturating count of lost slots while the FIFO waits
  always_comb begin
    starve_next_s = starve_r;
    stall_next_s  = stall_r;
    if (pop_s || empty_s) begin
      starve_next_s = {SW{1'b0}};
      stall_next_s  = 1'b0;
    end else begin
      if (starve_r != STARVE_MAX) begin
        starve_next_s = starve_r + {{(SW-1){1'b0}}, 1'b1};
      end else begin
        starve_next_s = starve_r;
      end
      stall_next_s = (starve_next_s == STARVE_MAX);
    end
  end

  // Output, pointer, occupancy and starvation registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_r     <= 1'b0;
      addr_r   <= 5'd0;
      data_r   <= 32'd0;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      starve_r <= {SW{1'b0}};
      stall_r  <= 1'b0;
    end else begin
      we_r     <= we_next_s;
      addr_r   <= addr_next_s;
      data_r   <= data_next_s;
      count_r  <= count_next_s;
      starve_r <= starve_next_s;
      stall_r  <= stall_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 37'd0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {lu_address_i, lu_data_i};
      end else begin
        mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
    end
  end

  assign lu_ready_o        = ready_s;
  assign stall_o           = stall_r;
  assign write_enable_3_o  = we_r;
  assign write_address_3_o = addr_r;
  assign write_data_3_o    = data_r;
  assign fifo_count_o      = count_r;

endmodule
